// File: rtl/ffn_pkg.sv
// Shared types, width helpers and saturation limits
// for the fully-connected classifier stage.
package ffn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_ARGMAX,
    S_OUTPUT
  } state_e;

  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  function automatic int fm_addr_w(input int depth);
    return clog2_min1(depth);
  endfunction

  function automatic int w_addr_w(input int k, input int depth);
    return clog2_min1(k * depth);
  endfunction

  function automatic int class_w(input int c);
    return clog2_min1(c);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/ffn_classifier_engine_fm_pingpong_ram.sv
// Ping-pong feature-map store: simple dual-port, registered read.
// Address MSB selects the bank.
module fm_pingpong_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 11
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ffn_classifier_engine.sv
// Fully-connected classifier: ping-pong capture, parallel
// saturating MACs against external weights, argmax result.
module ffn_classifier_engine
  import ffn_pkg::*;
#(
  parameter int NUM_KERNELS = 2,
  parameter int NUM_CLASSES = 2,
  parameter int FM_DEPTH    = 1024,
  parameter int DATA_W      = 8,
  parameter int WEIGHT_W    = 8,
  parameter int ACC_W       = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic pix_valid,
  output logic pix_ready,
  input  logic [NUM_KERNELS*DATA_W-1:0] pix_data,
  input  logic pix_last,
  output logic w_rden,
  output logic [w_addr_w(NUM_KERNELS, FM_DEPTH)-1:0] w_addr,
  input  logic [NUM_CLASSES*WEIGHT_W-1:0] w_data,
  output logic res_valid,
  input  logic res_ready,
  output logic [NUM_CLASSES*ACC_W-1:0] res_scores,
  output logic [class_w(NUM_CLASSES)-1:0] res_class,
  output logic [NUM_CLASSES-1:0] res_overflow
);

  localparam int FM_AW = fm_addr_w(FM_DEPTH);
  localparam int W_AW  = w_addr_w(NUM_KERNELS, FM_DEPTH);
  localparam int CW    = class_w(NUM_CLASSES);
  localparam int KW    = clog2_min1(NUM_KERNELS);
  localparam int PIX_W = NUM_KERNELS * DATA_W;
  localparam int P_W   = DATA_W + 1 + WEIGHT_W;
  localparam int S_W   = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
  localparam logic signed [S_W-1:0] SAT_HI = S_W'(sat_max(ACC_W));
  localparam logic signed [S_W-1:0] SAT_LO = S_W'(sat_min(ACC_W));

  state_e state_q, state_d;

  logic             alive_q;
  logic             fill_q, cmp_q;
  logic [1:0]       full_q, full_d;
  logic [FM_AW-1:0] wr_ptr_q;
  logic [FM_AW:0]   cnt_q [2];
  logic [FM_AW:0]   n_q;
  logic [KW-1:0]    k_q, k_d1;
  logic [FM_AW-1:0] a_q;
  logic             v1_q, v2_q, dr_q;
  logic [CW-1:0]    j_q, best_idx_q;
  logic signed [ACC_W-1:0] best_q;
  logic signed [ACC_W-1:0] acc [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]  ovf;
  logic [PIX_W-1:0] rd_data;

  logic accept, close, a_last, run_last, arg_last;
  logic res_take, run, clr;

  assign pix_ready = alive_q && !(&full_q);
  assign accept    = pix_valid && pix_ready;
  assign close     = accept && (pix_last ||
                     wr_ptr_q == FM_AW'(FM_DEPTH - 1));
  assign a_last    = ((FM_AW+1)'(a_q) + (FM_AW+1)'(1)) == n_q;
  assign run_last  = a_last && (k_q == KW'(NUM_KERNELS - 1));
  assign arg_last  = j_q == CW'(NUM_CLASSES - 1);
  assign run       = state_q == S_RUN;
  assign clr       = state_q == S_CLEAR;
  assign res_take  = (state_q == S_OUTPUT) && res_ready;

  assign res_valid    = state_q == S_OUTPUT;
  assign res_class    = best_idx_q;
  assign res_overflow = ovf;
  assign w_rden       = run;
  assign w_addr       = run ? W_AW'({k_q, a_q}) : '0;

  fm_pingpong_ram #(
    .WIDTH (PIX_W),
    .AW    (FM_AW + 1)
  ) u_ram (
    .clock   (clock),
    .wr_en   (accept),
    .wr_addr ({fill_q, wr_ptr_q}),
    .wr_data (pix_data),
    .rd_addr ({cmp_q, a_q}),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (full_q[cmp_q]) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_RUN;
      S_RUN:    if (run_last) state_d = S_DRAIN;
      S_DRAIN:  if (dr_q) state_d = S_ARGMAX;
      S_ARGMAX: if (arg_last) state_d = S_OUTPUT;
      S_OUTPUT: if (res_ready)
                  state_d = full_q[~cmp_q] ? S_CLEAR : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A closing bank and the bank being freed are never the same one.
  always_comb begin
    full_d = full_q;
    if (res_take) full_d[cmp_q] = 1'b0;
    if (close)    full_d[fill_q] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alive_q  <= 1'b0;
      fill_q   <= 1'b0;
      cmp_q    <= 1'b0;
      full_q   <= '0;
      wr_ptr_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      alive_q <= 1'b1;
      full_q  <= full_d;
      if (res_take) cmp_q <= ~cmp_q;
      if (close) begin
        cnt_q[fill_q] <= (FM_AW+1)'(wr_ptr_q) + (FM_AW+1)'(1);
        fill_q        <= ~fill_q;
        wr_ptr_q      <= '0;
      end else if (accept) begin
        wr_ptr_q <= wr_ptr_q + FM_AW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_q        <= '0;
      k_q        <= '0;
      a_q        <= '0;
      k_d1       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      dr_q       <= 1'b0;
      j_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      v1_q <= run;
      v2_q <= v1_q;
      k_d1 <= k_q;
      unique case (state_q)
        S_CLEAR: begin
          n_q  <= cnt_q[cmp_q];
          k_q  <= '0;
          a_q  <= '0;
          j_q  <= '0;
          dr_q <= 1'b0;
        end
        S_RUN: begin
          if (a_last) begin
            a_q <= '0;
            k_q <= k_q + KW'(1);
          end else begin
            a_q <= a_q + FM_AW'(1);
          end
        end
        S_DRAIN: dr_q <= 1'b1;
        S_ARGMAX: begin
          j_q <= j_q + CW'(1);
          // Strict greater-than keeps the lowest index on ties.
          if (j_q == '0 || acc[j_q] > best_q) begin
            best_q     <= acc[j_q];
            best_idx_q <= j_q;
          end
        end
        default: ;
      endcase
    end
  end

  logic [DATA_W-1:0]      pix_sel;
  logic signed [DATA_W:0] pix_s;

  assign pix_sel = rd_data[k_d1*DATA_W +: DATA_W];
  assign pix_s   = {1'b0, pix_sel};

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_mac
    logic signed [WEIGHT_W-1:0] w_s;
    logic signed [P_W-1:0]      prod_c, prod_q;
    logic signed [S_W-1:0]      sum;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       ovf_q;

    assign w_s    = w_data[c*WEIGHT_W +: WEIGHT_W];
    assign prod_c = P_W'(pix_s) * P_W'(w_s);
    assign sum    = S_W'(acc_q) + S_W'(prod_q);
    assign acc[c] = acc_q;
    assign ovf[c] = ovf_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        prod_q <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (v1_q) prod_q <= prod_c;
        if (clr) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
        end else if (v2_q) begin
          if (sum > SAT_HI) begin
            acc_q <= ACC_W'(SAT_HI);
            ovf_q <= 1'b1;
          end else if (sum < SAT_LO) begin
            acc_q <= ACC_W'(SAT_LO);
            ovf_q <= 1'b1;
          end else begin
            acc_q <= ACC_W'(sum);
          end
        end
      end
    end
  end

  always_comb begin
    res_scores = '0;
    for (int c = 0; c < NUM_CLASSES; c++)
      res_scores[c*ACC_W +: ACC_W] = acc[c];
  end

endmodule

// File: tb/tb_ffn_classifier_engine.sv
// Directed bench for ffn_classifier_engine: K=2, C=2,
// FM_DEPTH=4, ACC_W=16, behavioural weight RAM.
module tb_ffn_classifier_engine;

  localparam int K  = 2;
  localparam int C  = 2;
  localparam int D  = 4;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [K*DW-1:0] pix_data = '0;
  logic pix_last = 1'b0;
  logic w_rden;
  logic [2:0] w_addr;
  logic [C*WW-1:0] w_data = '0;
  logic [C*WW-1:0] w_nxt = '0;
  logic res_valid;
  logic res_ready = 1'b1;
  logic [C*AW-1:0] res_scores;
  logic [0:0] res_class;
  logic [C-1:0] res_overflow;

  logic [15:0] wmem [8];
  logic [2:0]  addr_log [$];
  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int stalls = 0;
  int lat = 0;
  int base = 0;
  int abase = 0;

  ffn_classifier_engine #(
    .NUM_KERNELS (K),
    .NUM_CLASSES (C),
    .FM_DEPTH    (D),
    .DATA_W      (DW),
    .WEIGHT_W    (WW),
    .ACC_W       (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .w_rden       (w_rden),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_scores   (res_scores),
    .res_class    (res_class),
    .res_overflow (res_overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (w_rden) begin
      w_nxt = wmem[w_addr];
      rd_cnt++;
      addr_log.push_back(w_addr);
    end
  end

  always @(posedge clock) w_data <= w_nxt;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int t = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    while (!pix_ready && t < 100) begin
      @(posedge clock); #1;
      t++;
      stalls++;
    end
    if (t == 100) chk("send_timeout", pix_ready, 1);
    @(posedge clock); #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    lat = 0;
    while (!res_valid && lat < 300) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_valid"}, res_valid, 1);
  endtask

  task automatic chk_res(input string tag,
                         input longint s0, input longint s1,
                         input int cls, input int ov);
    chk({tag, "_s0"}, $signed(res_scores[AW-1:0]), s0);
    chk({tag, "_s1"}, $signed(res_scores[2*AW-1:AW]), s1);
    chk({tag, "_cls"}, res_class, cls);
    chk({tag, "_ovf"}, res_overflow, ov);
  endtask

  task automatic take;
    @(posedge clock); #1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_ready", pix_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_rden", w_rden, 0);
    chk("rst_scores", res_scores, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    take();
    chk("rel_ready", pix_ready, 1);

    // 1: basic frame
    for (int i = 0; i < 8; i++) wmem[i] = {8'd2, 8'd1};
    base = rd_cnt;
    send({8'd0, 8'd1}, 1'b0);
    send({8'd0, 8'd2}, 1'b0);
    send({8'd0, 8'd3}, 1'b0);
    send({8'd0, 8'd4}, 1'b1);
    wait_res("t1");
    chk("t1_lat", lat, 14);
    chk_res("t1", 10, 20, 1, 0);
    chk("t1_rdcnt", rd_cnt - base, 8);
    take();

    // 2: short frame, address-dependent weights
    for (int i = 0; i < 8; i++) wmem[i] = {8'hFF, 8'(i + 1)};
    base  = rd_cnt;
    abase = addr_log.size();
    send({8'd3, 8'd5}, 1'b0);
    send({8'd4, 8'd6}, 1'b1);
    wait_res("t2");
    chk("t2_lat", lat, 10);
    chk("t2_rdcnt", rd_cnt - base, 4);
    chk("t2_a0", addr_log[abase + 0], 0);
    chk("t2_a1", addr_log[abase + 1], 1);
    chk("t2_a2", addr_log[abase + 2], 4);
    chk("t2_a3", addr_log[abase + 3], 5);
    chk_res("t2", 56, -18, 0, 0);
    take();

    // 3: auto-close, two back-to-back frames
    for (int i = 0; i < 8; i++)
      wmem[i] = (i < 4) ? {8'hFE, 8'd1} : {8'd5, 8'd1};
    stalls = 0;
    for (int i = 1; i <= 4; i++) send({8'd1, 8'(i)}, 1'b0);
    for (int i = 1; i <= 4; i++) send({8'd2, 8'd1}, 1'b0);
    chk("t3_stalls", stalls, 0);
    wait_res("t3a");
    chk_res("t3a", 14, 0, 0, 0);
    take();
    wait_res("t3b");
    chk_res("t3b", 12, 32, 1, 0);
    take();

    // 4: backpressure, both banks full
    res_ready = 1'b0;
    send({8'd1, 8'd2}, 1'b0);
    send({8'd1, 8'd3}, 1'b1);
    send({8'd4, 8'd0}, 1'b0);
    send({8'd4, 8'd1}, 1'b1);
    chk("t4_full_ready", pix_ready, 0);
    wait_res("t4c");
    chk_res("t4c", 7, 0, 0, 0);
    repeat (5) @(posedge clock);
    #1;
    chk("t4_hold_valid", res_valid, 1);
    chk("t4_hold_ready", pix_ready, 0);
    res_ready = 1'b1;
    take();
    chk("t4_freed_ready", pix_ready, 1);
    wait_res("t4d");
    chk_res("t4d", 9, 38, 1, 0);
    take();

    // 5: saturation, last coincides with full bank
    for (int i = 0; i < 8; i++) wmem[i] = 16'h817F;
    for (int i = 0; i < 4; i++) send(16'hFFFF, i == 3);
    wait_res("t5");
    chk_res("t5", 32767, -32768, 0, 3);
    take();
    repeat (20) @(posedge clock);
    #1;
    chk("t5_single_close", res_valid, 0);

    // 6: tie, then reset mid-RUN
    for (int i = 0; i < 8; i++) wmem[i] = {8'd3, 8'd3};
    send({8'd2, 8'd1}, 1'b0);
    send({8'd1, 8'd2}, 1'b1);
    wait_res("t6tie");
    chk_res("t6tie", 18, 18, 0, 0);
    take();
    for (int i = 0; i < 8; i++) wmem[i] = {8'd2, 8'd1};
    for (int i = 0; i < 4; i++) send({8'd0, 8'd9}, i == 3);
    repeat (4) @(posedge clock);
    #1;
    chk("t6_in_run", w_rden, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_ready", pix_ready, 0);
    chk("t6_rst_rden", w_rden, 0);
    chk("t6_rst_waddr", w_addr, 0);
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_scores", res_scores, 0);
    chk("t6_rst_cls", res_class, 0);
    chk("t6_rst_ovf", res_overflow, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    take();
    chk("t6_rel_ready", pix_ready, 1);
    send({8'd0, 8'd1}, 1'b0);
    send({8'd0, 8'd1}, 1'b1);
    wait_res("t6new");
    chk("t6_lat", lat, 10);
    chk_res("t6new", 2, 4, 1, 0);
    take();
    repeat (20) @(posedge clock);
    #1;
    chk("t6_no_residue", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
